// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller.
// State encoding and run-mode constants.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        RUN,
        STEP_WAIT,
        DONE
    } run_state_t;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_RUNN = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: reset sequencing, CPI pacing of pc_write,
// and stop on instruction budget, single-step or halt.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CPI        = 20,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] n_instr,
    input  logic             step,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             pc_write,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int PH_W = (CPI > 1) ? $clog2(CPI) : 1;
    localparam int HD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CPI - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(RST_CYCLES - 1);

    run_state_t       state, state_d;
    logic [PH_W-1:0]  phase, phase_d;
    logic [HD_W-1:0]  hold, hold_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic             pc_write_d;
    logic             cnt_clr, inc_instr, inc_cycle;
    logic             last_instr;

    assign last_instr = (mode_q == MODE_RUNN)
                     && ((instr_cnt + 1'b1) == budget_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_HOLD;
            phase    <= '0;
            hold     <= '0;
            mode_q   <= MODE_FREE;
            budget_q <= '0;
            pc_write <= 1'b0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            hold     <= hold_d;
            mode_q   <= mode_d;
            budget_q <= budget_d;
            pc_write <= pc_write_d;
        end
    end

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        hold_d    = hold;
        mode_d    = mode_q;
        budget_d  = budget_q;
        cnt_clr   = 1'b0;
        inc_instr = 1'b0;
        inc_cycle = 1'b0;
        unique case (state)
            RST_HOLD: begin
                if (hold == HD_LAST) state_d = IDLE;
                else hold_d = hold + 1'b1;
            end
            IDLE, DONE: begin
                if (start) begin
                    mode_d   = mode;
                    budget_d = n_instr;
                    cnt_clr  = 1'b1;
                    phase_d  = '0;
                    if ((mode == MODE_RUNN) && (n_instr == '0))
                        state_d = DONE;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                inc_cycle = 1'b1;
                if (phase == PH_LAST) begin
                    // strobe already on the wire; halt cannot retract it
                    inc_instr = 1'b1;
                    phase_d   = '0;
                    if (halt_req || last_instr)
                        state_d = DONE;
                    else if (mode_q == MODE_STEP)
                        state_d = STEP_WAIT;
                end else if (halt_req) begin
                    state_d = DONE;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            STEP_WAIT: begin
                phase_d = '0;
                if (halt_req) state_d = DONE;
                else if (step) state_d = RUN;
            end
            default: state_d = RST_HOLD;
        endcase
        pc_write_d = (state_d == RUN) && (phase_d == PH_LAST);
    end

    assign cpu_rst = (state == RST_HOLD);
    assign busy    = (state == RUN) || (state == STEP_WAIT);
    assign done    = (state == DONE);

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_instr),
        .cnt   (instr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_cycle),
        .cnt   (cycle_cnt)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl across three parameter sets.
// Inputs driven and outputs sampled on the falling edge.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] n_instr = '0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;

    logic        cpu_rst_a, pc_write_a, busy_a, done_a;
    logic [31:0] instr_a, cycle_a;
    logic        cpu_rst_b, pc_write_b, busy_b, done_b;
    logic [31:0] instr_b, cycle_b;
    logic        cpu_rst_c, pc_write_c, busy_c, done_c;
    logic [3:0]  instr_c, cycle_c;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(2), .CPI(20), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .n_instr(n_instr), .step(step), .halt_req(halt_req),
        .cpu_rst(cpu_rst_a), .pc_write(pc_write_a), .busy(busy_a),
        .done(done_a), .instr_cnt(instr_a), .cycle_cnt(cycle_a)
    );

    cpu_run_ctrl #(.RST_CYCLES(2), .CPI(4), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .n_instr(n_instr), .step(step), .halt_req(halt_req),
        .cpu_rst(cpu_rst_b), .pc_write(pc_write_b), .busy(busy_b),
        .done(done_b), .instr_cnt(instr_b), .cycle_cnt(cycle_b)
    );

    cpu_run_ctrl #(.RST_CYCLES(2), .CPI(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .n_instr(n_instr[3:0]), .step(step), .halt_req(halt_req),
        .cpu_rst(cpu_rst_c), .pc_write(pc_write_c), .busy(busy_c),
        .done(done_c), .instr_cnt(instr_c), .cycle_cnt(cycle_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [31:0] n);
        mode = m;
        n_instr = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int pulses;
        logic exp_pw;

        // reset values while rst_n low
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", cpu_rst_a, 1);
        chk("rst_pc_write", pc_write_a, 0);
        chk("rst_busy_done", {busy_a, done_a}, 0);
        chk("rst_counters", instr_a | cycle_a, 0);

        // cpu_rst held exactly two cycles after release
        rst_n = 1'b1;
        @(negedge clk);
        chk("hold_cycle1", cpu_rst_a, 1);
        @(negedge clk);
        chk("hold_released", cpu_rst_a, 0);
        chk("idle_outputs", {pc_write_a, busy_a, done_a}, 0);
        chk("idle_counters", instr_a | cycle_a, 0);

        // run-N, CPI=20, budget 41
        do_start(2'd2, 32'd41);
        chk("runn_busy", busy_a, 1);
        bad = 0;
        pulses = 0;
        for (int k = 0; k < 820; k++) begin
            exp_pw = ((k % 20) == 19);
            if (pc_write_a !== exp_pw) bad++;
            if (pc_write_a === 1'b1) pulses++;
            if (k == 20) chk("runn_instr_after_1", instr_a, 1);
            if (k == 100) chk("runn_cycle_mid", cycle_a, 100);
            if (done_a !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("runn_pulse_pattern", bad, 0);
        chk("runn_pulse_count", pulses, 41);
        chk("runn_done", done_a, 1);
        chk("runn_pw_low", pc_write_a, 0);
        chk("runn_busy_low", busy_a, 0);
        chk("runn_instr", instr_a, 41);
        chk("runn_cycle", cycle_a, 820);

        // free-run from DONE, ignored start, halt at phase 10
        do_start(2'd0, 32'd0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 5) begin
                mode = 2'd2;
                n_instr = 32'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 6) chk("ignored_start_cycle", cycle_a, 6);
            if (k == 20)
                chk("ignored_start_state", {busy_a, done_a, instr_a[1:0]},
                    {1'b1, 1'b0, 2'd1});
            if (pc_write_a !== ((k % 20) == 19)) bad++;
            @(negedge clk);
        end
        chk("free_pw_pattern", bad, 0);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("halt_done", done_a, 1);
        chk("halt_no_pw", pc_write_a, 0);
        chk("halt_instr", instr_a, 1);
        chk("halt_cycle", cycle_a, 31);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (pc_write_a !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("halt_quiet", bad, 0);
        chk("halt_frozen", {instr_a[15:0], cycle_a[15:0]}, {16'd1, 16'd31});

        // run-N with zero budget
        do_start(2'd2, 32'd0);
        chk("zero_done", {done_a, busy_a}, 2'b10);
        chk("zero_cleared", instr_a | cycle_a, 0);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (pc_write_a !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("zero_no_pw", bad, 0);

        // single-step, CPI=4
        do_reset();
        do_start(2'd1, 32'd0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (pc_write_b !== (k == 3)) bad++;
            @(negedge clk);
        end
        chk("step_first_pw", bad, 0);
        repeat (4) @(negedge clk);
        chk("step_wait_state", {busy_b, done_b, pc_write_b}, 3'b100);
        chk("step_wait_instr", instr_b, 1);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            bad = 0;
            for (int j = 0; j < 4; j++) begin
                if (pc_write_b !== (j == 3)) bad++;
                @(negedge clk);
            end
            chk("step_pw_timing", bad, 0);
            chk("step_instr", instr_b, s + 2);
            repeat (2) @(negedge clk);
        end
        chk("step_cycle", cycle_b, 16);
        step = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        step = 1'b0;
        halt_req = 1'b0;
        chk("step_halt_wins", {done_b, busy_b}, 2'b10);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("step_ignored_in_done", {done_b, pc_write_b}, 2'b10);

        // CPI=1 free-run (reserved mode) with 4-bit saturation
        do_reset();
        do_start(2'd3, 32'd0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (pc_write_c !== 1'b1) bad++;
            if (k == 7) chk("cpi1_instr_mid", instr_c, 7);
            @(negedge clk);
        end
        chk("cpi1_pw_continuous", bad, 0);
        chk("sat_instr", instr_c, 15);
        chk("sat_cycle", cycle_c, 15);

        // asynchronous reset mid-run
        chk("pre_reset_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("async_c_outputs", {cpu_rst_c, pc_write_c, busy_c, done_c},
            4'b1000);
        chk("async_c_counters", {instr_c, cycle_c}, 0);
        chk("async_a_counters", instr_a | cycle_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller for the single-cycle CPU core. It sequences CPU reset release, paces instruction retirement by generating the `pc_write` strobe at a fixed cycles-per-instruction rate, and stops the core after a programmed instruction count, on single-step or on halt request. It sits between the clock/reset source and `top`, and drives `top`'s `rst` and `pc_write` inputs. It replaces the fixed timed reset-then-run sequence with a programmable, counted one.

## Interface
- `RST_CYCLES`, default 2: cycles `cpu_rst` is held high after reset deassertion; must be ≥1.
- `CPI`, default 20: clock cycles per instruction; must be ≥1.
- `CNT_W`, default 32: width of the instruction and cycle counters.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; accepted in IDLE or DONE only.
- `mode` input 2: 0 = free-run, 1 = single-step, 2 = run-N, 3 = reserved (treated as free-run). Sampled on the accepted `start`.
- `n_instr` input CNT_W: instruction budget for run-N. Sampled on the accepted `start`.
- `step` input 1: one-cycle pulse; releases one instruction in STEP_WAIT.
- `halt_req` input 1: level; stops execution.
- `cpu_rst` output 1: active-high reset to the core.
- `pc_write` output 1: one-cycle retire strobe to the core.
- `busy` output 1: high in RUN and STEP_WAIT.
- `done` output 1: high in DONE.
- `instr_cnt` output CNT_W: instructions retired since the last accepted `start`.
- `cycle_cnt` output CNT_W: cycles spent in RUN since the last accepted `start`.

## Operation
- States: RST_HOLD, IDLE, RUN, STEP_WAIT, DONE.
- Reset values while `rst_n`=0: state RST_HOLD, `cpu_rst`=1, `pc_write`=0, `busy`=0, `done`=0, `instr_cnt`=0, `cycle_cnt`=0, phase=0, hold counter=0.
- RST_HOLD: `cpu_rst`=1 for exactly RST_CYCLES cycles after `rst_n` rises, then IDLE with `cpu_rst`=0.
- IDLE or DONE with `start`=1: latch `mode` and `n_instr`, clear both counters and phase, then enter RUN.
  - Exception: run-N with `n_instr`=0 goes directly to DONE; no `pc_write` is issued.
- RUN: phase counts 0..CPI-1 and `cycle_cnt` increments every cycle. When phase = CPI-1:
  - `pc_write`=1 for that cycle; `instr_cnt` increments; phase returns to 0.
  - Run-N: if `instr_cnt`+1 = budget, go to DONE.
  - Single-step: go to STEP_WAIT.
  - Free-run: stay in RUN.
- STEP_WAIT: phase is held at 0. `step` returns to RUN. `halt_req` goes to DONE. If both are asserted, `halt_req` wins.
- `halt_req` in RUN: go to DONE on the next edge and abandon the partial instruction with no `pc_write`. `halt_req` on the same cycle as a `pc_write` does not suppress that strobe.
- `start` in RUN or STEP_WAIT is ignored. `step` outside STEP_WAIT is ignored.
- Counters saturate at all-ones; they never wrap.
- `rst_n` low in any state gives immediate return to the reset values.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge T: `busy`=1 from T. The first `pc_write` is high in cycle T+CPI-1 to T+CPI.
- Free-run: `pc_write` period is exactly CPI cycles. With CPI=1, `pc_write` stays high continuously.
- Run-N: DONE is entered on the edge that ends the last `pc_write` cycle, so `done` rises together with `pc_write` falling.
- `step` sampled at edge S: the next `pc_write` is at S+CPI-1.

## Structure
- Shared package `cpu_ctrl_pkg`: state enum `run_state_t`, mode constants `MODE_FREE`, `MODE_STEP`, `MODE_RUNN`.
- One sub-module, `sat_counter`, parametrised by width, with clear, increment and saturate. Instantiate it for `instr_cnt` and `cycle_cnt`.

## Test plan
- Reset: with RST_CYCLES=2, release `rst_n` → `cpu_rst` is high for exactly 2 cycles, then IDLE with all outputs 0.
- Run-N: CPI=20, `n_instr`=41 → 41 `pc_write` pulses spaced 20 cycles apart, then `done`=1, `instr_cnt`=41, `cycle_cnt`=820.
- Single-step: CPI=4, mode 1 → one pulse, then STEP_WAIT. Three `step` pulses → 4 pulses total, `instr_cnt`=4.
- Halt mid-instruction: `halt_req` at phase 10 → `done` on the next cycle, no `pc_write`, counters frozen.
- Edge cases: run-N with `n_instr`=0 → DONE and no pulse. CNT_W=4 free-run → `instr_cnt` holds at 15. `rst_n` low mid-RUN → immediate return to reset values.
